// File: rtl/ckpt_regfile_pkg.sv
// Shared constants and tag layout for the checkpointed rename/register file.
// A tag is {busy, rob_pos}; busy=0 means the register value is architectural.
`ifndef CKPT_TAG_W
`define CKPT_TAG_W(rob_w) ((rob_w) + 1)
`endif

package ckpt_regfile_pkg;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int ROB_W = 4;
  localparam int NRP   = 2;
  localparam int NCKPT = 4;
  localparam int TAG_W = `CKPT_TAG_W(ROB_W);

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] rob_pos;
  } tag_t;

  function automatic tag_t busy_tag(input logic [ROB_W-1:0] pos);
    tag_t t;
    t.busy    = 1'b1;
    t.rob_pos = pos;
    return t;
  endfunction
endpackage

// File: rtl/ckpt_regfile_if.sv
// Bus bundle for ckpt_regfile: read ports, issue, commit and checkpoint control.
interface ckpt_regfile_if #(
  parameter int XLEN  = ckpt_regfile_pkg::XLEN,
  parameter int NREG  = ckpt_regfile_pkg::NREG,
  parameter int ROB_W = ckpt_regfile_pkg::ROB_W,
  parameter int NRP   = ckpt_regfile_pkg::NRP,
  parameter int NCKPT = ckpt_regfile_pkg::NCKPT
);
  import ckpt_regfile_pkg::*;
  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);
  localparam int TW = `CKPT_TAG_W(ROB_W);

  logic                rdy;
  logic [NRP*IW-1:0]   rd_idx;
  logic [NRP*XLEN-1:0] rd_val;
  logic [NRP*TW-1:0]   rd_tag;
  logic                issue;
  logic [IW-1:0]       issue_rd;
  logic [ROB_W-1:0]    issue_rob_pos;
  logic                issue_ckpt;
  logic [CW-1:0]       ckpt_id;
  logic                ckpt_full;
  logic                commit;
  logic [IW-1:0]       commit_rd;
  logic [XLEN-1:0]     commit_val;
  logic [ROB_W-1:0]    commit_rob_pos;
  logic                ckpt_release;
  logic                restore;
  logic [CW-1:0]       restore_id;
  logic                flush;

  modport master (
    output rdy, rd_idx, issue, issue_rd, issue_rob_pos, issue_ckpt,
           commit, commit_rd, commit_val, commit_rob_pos,
           ckpt_release, restore, restore_id, flush,
    input  rd_val, rd_tag, ckpt_id, ckpt_full
  );

  modport slave (
    input  rdy, rd_idx, issue, issue_rd, issue_rob_pos, issue_ckpt,
           commit, commit_rd, commit_val, commit_rob_pos,
           ckpt_release, restore, restore_id, flush,
    output rd_val, rd_tag, ckpt_id, ckpt_full
  );
endinterface

// File: rtl/ckpt_regfile_ckpt_queue.sv
// Circular-queue bookkeeping for checkpoint slots: head (oldest), tail (next free), count.
module ckpt_queue #(
  parameter int  NCKPT = ckpt_regfile_pkg::NCKPT,
  localparam int CW    = $clog2(NCKPT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          alloc,
  input  logic          rel,
  input  logic          flush,
  input  logic          restore,
  input  logic [CW-1:0] restore_id,
  output logic [CW-1:0] head,
  output logic [CW-1:0] tail,
  output logic [CW:0]   count,
  output logic          full
);
  import ckpt_regfile_pkg::*;

  assign full = (count == (CW+1)'(NCKPT));

  // alloc/rel arrive already qualified against full/empty and flush/restore
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else if (restore) begin
        tail  <= restore_id;
        count <= {1'b0, restore_id - head};
      end else begin
        if (alloc) tail <= tail + 1'b1;
        if (rel)   head <= head + 1'b1;
        count <= count + {{CW{1'b0}}, alloc} - {{CW{1'b0}}, rel};
      end
    end
  end
endmodule

// File: rtl/ckpt_regfile.sv
// Register file with rename tags and a circular queue of tag-table checkpoints
// for branch recovery; values are never rolled back, only tags.
module ckpt_regfile #(
  parameter int XLEN  = ckpt_regfile_pkg::XLEN,
  parameter int NREG  = ckpt_regfile_pkg::NREG,
  parameter int ROB_W = ckpt_regfile_pkg::ROB_W,
  parameter int NRP   = ckpt_regfile_pkg::NRP,
  parameter int NCKPT = ckpt_regfile_pkg::NCKPT
) (
  input logic           clk,
  input logic           rst,
  ckpt_regfile_if.slave bus
);
  import ckpt_regfile_pkg::*;
  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);
  localparam int TW = `CKPT_TAG_W(ROB_W);

  logic [XLEN-1:0] vals      [NREG];
  logic [TW-1:0]   tags      [NREG];
  logic [TW-1:0]   tags_nxt  [NREG];
  logic [TW-1:0]   ckpt_tags [NCKPT][NREG];

  logic [CW-1:0]    head, tail;
  logic [CW:0]      count;
  logic             full;
  logic [NCKPT-1:0] slot_vld;
  logic [TW-1:0]    ctag;
  logic             do_commit, restore_ok, alloc, rel;

  assign ctag       = {1'b1, bus.commit_rob_pos};
  assign do_commit  = bus.commit && (bus.commit_rd != '0);
  assign restore_ok = bus.restore && slot_vld[bus.restore_id];
  assign alloc      = bus.issue && bus.issue_ckpt && !full && !bus.flush && !restore_ok;
  assign rel        = bus.ckpt_release && (count != '0) && !bus.flush && !restore_ok;

  always_comb begin
    for (int s = 0; s < NCKPT; s++)
      slot_vld[s] = ({1'b0, CW'(s) - head} < count);
  end

  // Next live tag table: commit clear, then flush / restore / issue in priority order
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      tags_nxt[r] = tags[r];
      if (do_commit && IW'(r) == bus.commit_rd && tags[r] == ctag)
        tags_nxt[r] = '0;
      if (bus.flush) begin
        tags_nxt[r] = '0;
      end else if (restore_ok) begin
        tags_nxt[r] = ckpt_tags[bus.restore_id][r];
        if (do_commit && IW'(r) == bus.commit_rd && ckpt_tags[bus.restore_id][r] == ctag)
          tags_nxt[r] = '0;
      end else if (bus.issue && bus.issue_rd != '0 && IW'(r) == bus.issue_rd) begin
        tags_nxt[r] = {1'b1, bus.issue_rob_pos};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        vals[r] <= '0;
        tags[r] <= '0;
      end
    end else if (bus.rdy) begin
      if (do_commit) vals[bus.commit_rd] <= bus.commit_val;
      for (int r = 0; r < NREG; r++) tags[r] <= tags_nxt[r];
    end
  end

  // Slot contents need no reset: a slot is only read while it is valid
  always_ff @(posedge clk) begin
    if (!rst && bus.rdy) begin
      for (int s = 0; s < NCKPT; s++) begin
        for (int r = 0; r < NREG; r++) begin
          if (alloc && CW'(s) == tail)
            ckpt_tags[s][r] <= tags_nxt[r];
          else if (slot_vld[s] && do_commit && IW'(r) == bus.commit_rd && ckpt_tags[s][r] == ctag)
            ckpt_tags[s][r] <= '0;
        end
      end
    end
  end

  ckpt_queue #(.NCKPT(NCKPT)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .rdy        (bus.rdy),
    .alloc      (alloc),
    .rel        (rel),
    .flush      (bus.flush),
    .restore    (restore_ok),
    .restore_id (bus.restore_id),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .full       (full)
  );

  assign bus.ckpt_full = full;
  assign bus.ckpt_id   = tail;

  logic [NRP-1:0][XLEN-1:0] rd_val_a;
  logic [NRP-1:0][TW-1:0]   rd_tag_a;

  // A commit retiring the current producer is forwarded to same-cycle readers
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [IW-1:0] idx;
    logic          hit;
    assign idx         = bus.rd_idx[p*IW +: IW];
    assign hit         = do_commit && (bus.commit_rd == idx) && (tags[idx] == ctag);
    assign rd_val_a[p] = (idx == '0) ? '0 : (hit ? bus.commit_val : vals[idx]);
    assign rd_tag_a[p] = (idx == '0 || hit) ? '0 : tags[idx];
  end

  assign bus.rd_val = rd_val_a;
  assign bus.rd_tag = rd_tag_a;
endmodule

// File: tb/tb_ckpt_regfile.sv
// Scoreboard bench for ckpt_regfile: directed scenarios plus random traffic, both
// predicted by a queue-of-snapshots reference model.
module tb_ckpt_regfile;
  import ckpt_regfile_pkg::*;
  localparam int IW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);

  typedef tag_t [NREG-1:0] tvec_t;
  typedef struct packed {
    logic [NRP-1:0][XLEN-1:0]  val;
    logic [NRP-1:0][TAG_W-1:0] tag;
    logic [CW-1:0]             id;
    logic                      full;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ckpt_regfile_if bus_if ();
  ckpt_regfile dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  // Reference model state
  logic [XLEN-1:0] mval [NREG];
  tvec_t           mtag;
  tvec_t           ckq[$];
  int              mtail;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) mval[r] = '0;
    mtag  = '0;
    ckq.delete();
    mtail = 0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    logic [IW-1:0] idx;
    for (int p = 0; p < NRP; p++) begin
      idx = bus_if.rd_idx[p*IW +: IW];
      if (idx == 0) begin
        e.val[p] = '0;
        e.tag[p] = '0;
      end else if (bus_if.commit && bus_if.commit_rd == idx &&
                   mtag[idx] == busy_tag(bus_if.commit_rob_pos)) begin
        e.val[p] = bus_if.commit_val;
        e.tag[p] = '0;
      end else begin
        e.val[p] = mval[idx];
        e.tag[p] = mtag[idx];
      end
    end
    e.id   = CW'(mtail);
    e.full = (ckq.size() == NCKPT);
    return e;
  endfunction

  task automatic model_update();
    tag_t  ct;
    tvec_t nt, snap;
    int    hd, k;
    logic  dc, alc;
    if (rst) begin
      model_reset();
      return;
    end
    if (!bus_if.rdy) return;
    ct = busy_tag(bus_if.commit_rob_pos);
    dc = bus_if.commit && bus_if.commit_rd != 0;
    nt = mtag;
    if (dc) begin
      mval[bus_if.commit_rd] = bus_if.commit_val;
      if (mtag[bus_if.commit_rd] == ct) nt[bus_if.commit_rd] = '0;
      for (int i = 0; i < ckq.size(); i++) begin
        snap = ckq[i];
        if (snap[bus_if.commit_rd] == ct) snap[bus_if.commit_rd] = '0;
        ckq[i] = snap;
      end
    end
    hd = (mtail - ckq.size()) & (NCKPT - 1);
    k  = (int'(bus_if.restore_id) - hd) & (NCKPT - 1);
    if (bus_if.flush) begin
      nt = '0;
      ckq.delete();
    end else if (bus_if.restore && k < ckq.size()) begin
      nt = ckq[k];
      while (ckq.size() > k) ckq.delete(ckq.size() - 1);
      mtail = int'(bus_if.restore_id);
    end else begin
      if (bus_if.issue && bus_if.issue_rd != 0) nt[bus_if.issue_rd] = busy_tag(bus_if.issue_rob_pos);
      alc = bus_if.issue && bus_if.issue_ckpt && (ckq.size() < NCKPT);
      if (bus_if.ckpt_release && ckq.size() > 0) ckq.delete(0);
      if (alc) begin
        ckq.push_back(nt);
        mtail = (mtail + 1) % NCKPT;
      end
    end
    mtag = nt;
  endtask

  // One cycle: record what the DUT must show now, then advance the model past the edge
  task automatic step();
    expq.push_back(predict());
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_idle();
    rst                 = 1'b0;
    bus_if.rdy          = 1'b1;
    bus_if.issue        = 1'b0;
    bus_if.issue_rd     = '0;
    bus_if.issue_rob_pos = '0;
    bus_if.issue_ckpt   = 1'b0;
    bus_if.commit       = 1'b0;
    bus_if.commit_rd    = '0;
    bus_if.commit_val   = '0;
    bus_if.commit_rob_pos = '0;
    bus_if.ckpt_release = 1'b0;
    bus_if.restore      = 1'b0;
    bus_if.restore_id   = '0;
    bus_if.flush        = 1'b0;
  endtask

  task automatic iss(input int rd, input int rob, input bit ck);
    bus_if.issue         = 1'b1;
    bus_if.issue_rd      = IW'(rd);
    bus_if.issue_rob_pos = ROB_W'(rob);
    bus_if.issue_ckpt    = ck;
  endtask

  task automatic cmt(input int rd, input int rob, input logic [XLEN-1:0] v);
    bus_if.commit         = 1'b1;
    bus_if.commit_rd      = IW'(rd);
    bus_if.commit_rob_pos = ROB_W'(rob);
    bus_if.commit_val     = v;
  endtask

  task automatic rd(input int p, input int idx);
    bus_if.rd_idx[p*IW +: IW] = IW'(idx);
  endtask

  task automatic rand_inputs();
    rst                   = ($urandom_range(99) == 0);
    bus_if.rdy            = ($urandom_range(9) != 0);
    bus_if.issue          = 1'($urandom_range(1));
    bus_if.issue_rd       = IW'($urandom_range(7));
    bus_if.issue_rob_pos  = ROB_W'($urandom);
    bus_if.issue_ckpt     = ($urandom_range(3) == 0);
    bus_if.commit         = 1'($urandom_range(1));
    bus_if.commit_rd      = IW'($urandom_range(7));
    bus_if.commit_rob_pos = ($urandom_range(3) != 0) ? mtag[bus_if.commit_rd].rob_pos : ROB_W'($urandom);
    bus_if.commit_val     = XLEN'($urandom);
    bus_if.ckpt_release   = ($urandom_range(6) == 0);
    bus_if.restore        = ($urandom_range(15) == 0);
    bus_if.restore_id     = CW'($urandom);
    bus_if.flush          = ($urandom_range(29) == 0);
    for (int p = 0; p < NRP; p++)
      bus_if.rd_idx[p*IW +: IW] = ($urandom_range(1) == 1) ? bus_if.commit_rd : IW'($urandom_range(7));
  endtask

  // Monitor: the DUT presents a response every cycle; compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int p = 0; p < NRP; p++) begin
          chk($sformatf("rd_val%0d", p), 64'(bus_if.rd_val[p*XLEN +: XLEN]), 64'(e.val[p]));
          chk($sformatf("rd_tag%0d", p), 64'(bus_if.rd_tag[p*TAG_W +: TAG_W]), 64'(e.tag[p]));
        end
        chk("ckpt_id", 64'(bus_if.ckpt_id), 64'(e.id));
        chk("ckpt_full", 64'(bus_if.ckpt_full), 64'(e.full));
      end
    end
  end

  initial begin
    int id0;
    bus_if.rd_idx = '0;
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    set_idle();
    rd(0, 5); rd(1, 0);
    step();

    // Issue then same-cycle commit forwarding
    iss(5, 3, 0); step();
    set_idle(); cmt(5, 3, 'h1234); step();
    set_idle(); step();

    // Younger rename survives an older commit
    iss(5, 3, 0); step();
    set_idle(); iss(5, 7, 0); step();
    set_idle(); cmt(5, 3, 'hA); step();
    set_idle(); step();

    // Checkpoint restore, without and with an intervening commit
    rd(1, 6);
    id0 = mtail;
    set_idle(); iss(6, 1, 1); step();
    set_idle(); iss(6, 2, 0); step();
    set_idle(); bus_if.restore = 1'b1; bus_if.restore_id = CW'(id0); step();
    set_idle(); step();
    id0 = mtail;
    iss(6, 1, 1); step();
    set_idle(); iss(6, 2, 0); step();
    set_idle(); cmt(6, 1, 'h66); step();
    set_idle(); bus_if.restore = 1'b1; bus_if.restore_id = CW'(id0); step();
    set_idle(); step();

    // Fill all slots, one extra request, release, then wrap the id
    for (int i = 0; i < NCKPT + 1; i++) begin
      set_idle(); iss(1 + i, i, 1); step();
    end
    set_idle(); bus_if.ckpt_release = 1'b1; step();
    set_idle(); iss(2, 9, 1); step();
    set_idle(); bus_if.ckpt_release = 1'b1; iss(3, 10, 1); step();

    // Flush with same-cycle issue and commit
    rd(0, 7);
    set_idle(); iss(7, 2, 0); step();
    set_idle(); bus_if.flush = 1'b1; iss(7, 4, 1); cmt(7, 2, 9); step();
    set_idle(); step();

    // Register 0 is immune; reset in mid-sequence
    rd(0, 0); rd(1, 3);
    set_idle(); iss(0, 5, 0); cmt(0, 5, 'hDEAD); step();
    set_idle(); iss(3, 4, 1); step();
    set_idle(); rst = 1'b1; iss(3, 6, 0); step();
    set_idle(); rd(1, 7); step();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    set_idle();
    for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ckpt_regfile.md
CKPT_REGFILE -- requirements
Module: ckpt_regfile

Interface
REQ-001 Parameters (name, default, meaning): XLEN, 32, data width; NREG, 32, architectural registers; ROB_W, 4, ROB index bits; NRP, 2, read ports; NCKPT, 4, checkpoint slots (power of 2).
REQ-002 Clock and reset: reset rst, synchronous, active-high; clock clk.
REQ-003 Ports (name  direction  width  meaning): clk  in  1  clock; rst  in  1  sync reset; rdy  in  1  global enable, state frozen when low.
REQ-004 rd_idx  in  NRP*log2(NREG)  read register indices; rd_val  out  NRP*XLEN  values; rd_tag  out  NRP*(ROB_W+1)  {busy, rob_pos}.
REQ-005 issue  in  1; issue_rd  in  log2(NREG); issue_rob_pos  in  ROB_W; issue_ckpt  in  1, save checkpoint for this instruction; ckpt_id  out  log2(NCKPT), slot allocated this cycle; ckpt_full  out  1.
REQ-006 commit  in  1; commit_rd  in  log2(NREG); commit_val  in  XLEN; commit_rob_pos  in  ROB_W.
REQ-007 ckpt_release  in  1, oldest checkpoint resolved correct; restore  in  1; restore_id  in  log2(NCKPT); flush  in  1, full rollback.

Function
REQ-010 Each register holds val and tag {busy, rob_pos}; busy=0 means val is architectural and ready.
REQ-011 Register 0: rd_val=0, rd_tag=0 always; writes and renames to index 0 ignored.
REQ-012 Read ports combinational; if commit && commit_rd==rd_idx!=0 && tag[commit_rd]=={1,commit_rob_pos}: rd_val=commit_val, rd_tag=0; otherwise stored val/tag.
REQ-013 Commit (commit_rd!=0): val written next edge; tag cleared only when it equals {1,commit_rob_pos}; same match-and-clear applied in every valid checkpoint.
REQ-014 Issue (issue_rd!=0): tag[issue_rd] <= {1,issue_rob_pos}; same-cycle commit to same register applied first, issue tag wins.
REQ-015 Checkpoints form a circular queue: head (oldest), tail (next free), count 0..NCKPT; ckpt_full = (count==NCKPT); ckpt_id = tail.
REQ-016 issue && issue_ckpt && !ckpt_full: slot tail stores the tag table after this cycle's commit and issue updates; tail++ mod NCKPT; count++. With ckpt_full asserted, request ignored (upstream stalls).
REQ-017 ckpt_release with count>0: head++ mod NCKPT, count--; with count==0, ignored.
REQ-018 restore (valid restore_id): live tags <= slot restore_id contents with this cycle's commit clear applied; restore_id and all younger slots discarded (tail <= restore_id, count adjusted); issue same cycle ignored; vals untouched.
REQ-019 flush: all live tags cleared, all checkpoints invalidated (head=tail, count=0); commit val write still performed; issue, restore, ckpt_release same cycle ignored.
REQ-020 Priority: flush > restore > issue; commit val write always applies; ckpt_release and issue_ckpt in same cycle: count net unchanged.
REQ-021 Wrap-around of head/tail modulo NCKPT, no overflow of count.
REQ-022 rdy low: no state change; read ports remain combinational.

Reset
REQ-030 rst: all val=0, all tags=0, head=tail=count=0; outputs ckpt_full=0, ckpt_id=0, rd_tag=0, rd_val=0 for any index.
REQ-031 rst takes priority over rdy and all inputs.

Structure
REQ-040 Shared package holds XLEN, NREG, ROB_W, tag width macro, and tag field layout {busy, rob_pos}.
REQ-041 One sub-module ckpt_queue: head/tail/count bookkeeping, ckpt_full, ckpt_id; tag storage stays in ckpt_regfile.

Verification
REQ-050 Issue x5 rob 3, then read x5 -> tag {1,3}; commit x5 rob 3 val 0x1234 same cycle as read -> rd_val=0x1234, tag 0; next cycle stored.
REQ-051 Issue x5 rob 3, issue x5 rob 7, commit rob 3 val 0xA -> val=0xA, tag stays {1,7}.
REQ-052 Issue x6 rob 1 with ckpt (id 0), issue x6 rob 2, restore 0 -> tag[x6]={1,1}, count 0; commit rob 1 before restore -> tag 0 after restore.
REQ-053 Allocate 4 checkpoints -> ckpt_full=1, 5th ignored; release one -> ckpt_full=0, next id wraps to 0.
REQ-054 Flush with issue x7 and commit x7 rob 2 val 9 same cycle -> all tags 0, val[x7]=9, count 0.
REQ-055 Issue/commit targeting x0 -> rd_val 0, rd_tag 0 throughout; rst mid-sequence -> all outputs zero next cycle.
